// File: rtl/bnn_pkg.sv
// Shared types and constants for the BNN image-load / inference controller.
package bnn_pkg;

  localparam int        IMG_PIXELS    = 784;
  localparam int        BYTES_PER_IMG = IMG_PIXELS / 8;
  localparam logic [7:0] ERR_CLASS    = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } bnn_ctrl_state_t;

  function automatic int byte_cnt_width(input int pixels);
    return $clog2(pixels / 8 + 1);
  endfunction

endpackage

// File: rtl/bnn_controller_if.sv
// Host-side byte stream and result handshake of the BNN controller.
interface bnn_controller_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       result_valid;
  logic [7:0] result_class;
  logic       result_ack;

  modport master (
    output rx_data, rx_valid, result_ack,
    input  rx_ready, result_valid, result_class
  );

  modport slave (
    input  rx_data, rx_valid, result_ack,
    output rx_ready, result_valid, result_class
  );

endinterface

// File: rtl/bnn_img_loader.sv
// Counts accepted pixel bytes and unpacks them MSB-first into the image register.
module bnn_img_loader #(
  parameter int IMG_PIXELS = bnn_pkg::IMG_PIXELS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cnt_clr_i,
  input  logic       accept_i,
  input  logic [7:0] byte_i,
  output logic       last_o,
  output logic       core_img_o [0:IMG_PIXELS-1]
);
  import bnn_pkg::*;

  localparam int NBYTES = IMG_PIXELS / 8;
  localparam int CW     = byte_cnt_width(IMG_PIXELS);

  logic [CW-1:0]         cnt_q;
  logic [IMG_PIXELS-1:0] img_q;
  logic [7:0]            byte_rev;

  // Pixel 8k+i takes bit 7-i of byte k.
  for (genvar gi = 0; gi < 8; gi++) begin : g_rev
    assign byte_rev[gi] = byte_i[7-gi];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      img_q <= '0;
    end else begin
      if (cnt_clr_i)
        cnt_q <= '0;
      else if (accept_i)
        cnt_q <= cnt_q + 1'b1;
      if (accept_i) begin
        for (int k = 0; k < NBYTES; k++) begin
          if (cnt_q == CW'(k))
            img_q[8*k +: 8] <= byte_rev;
        end
      end
    end
  end

  assign last_o = (cnt_q == CW'(NBYTES - 1));

  for (genvar gi = 0; gi < IMG_PIXELS; gi++) begin : g_img
    assign core_img_o[gi] = img_q[gi];
  end

endmodule

// File: rtl/bnn_controller.sv
// BNN inference controller: loads a packed image, starts the core, returns the class.
// Optional WAIT watchdog enabled by defining BNN_CTRL_TIMEOUT_EN.
module bnn_controller #(
  parameter int IMG_PIXELS     = bnn_pkg::IMG_PIXELS,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  bnn_controller_if.slave  bus,
  input  logic             clear,
  output logic             core_start,
  output logic             core_img [0:IMG_PIXELS-1],
  input  logic             core_result_ready,
  input  logic [7:0]       core_result,
  output logic             busy,
  output logic             error
);
  import bnn_pkg::*;

  bnn_ctrl_state_t state_q;
  logic            core_start_q;
  logic            result_valid_q;
  logic [7:0]      result_class_q;
  logic            busy_q;
  logic            rdy_prev_q;

  logic rx_ready;
  logic accept;
  logic last_byte;
  logic rdy_rise;
  logic cnt_clr;

  assign rx_ready = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  // clear wins over a byte arriving in the same cycle
  assign accept   = bus.rx_valid && rx_ready && !clear;
  assign rdy_rise = core_result_ready && !rdy_prev_q;
  assign cnt_clr  = clear || ((state_q == ST_DONE) && bus.result_ack);

  bnn_img_loader #(.IMG_PIXELS(IMG_PIXELS)) u_loader (
    .clk        (clk),
    .rst_n      (rst_n),
    .cnt_clr_i  (cnt_clr),
    .accept_i   (accept),
    .byte_i     (bus.rx_data),
    .last_o     (last_byte),
    .core_img_o (core_img)
  );

`ifdef BNN_CTRL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q;
  logic            error_q;
  logic            wd_expired;
  assign wd_expired = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
  assign error      = error_q;
`else
  assign error = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      core_start_q   <= 1'b0;
      result_valid_q <= 1'b0;
      result_class_q <= '0;
      busy_q         <= 1'b0;
      rdy_prev_q     <= 1'b0;
`ifdef BNN_CTRL_TIMEOUT_EN
      wd_q           <= '0;
      error_q        <= 1'b0;
`endif
    end else begin
      rdy_prev_q   <= core_result_ready;
      core_start_q <= 1'b0;
      if (clear) begin
        state_q        <= ST_IDLE;
        result_valid_q <= 1'b0;
        busy_q         <= 1'b0;
`ifdef BNN_CTRL_TIMEOUT_EN
        error_q        <= 1'b0;
`endif
      end else begin
        case (state_q)
          ST_IDLE, ST_LOAD: begin
            if (accept) begin
              busy_q <= 1'b1;
              if (last_byte) begin
                state_q      <= ST_START;
                core_start_q <= 1'b1;
              end else begin
                state_q <= ST_LOAD;
              end
            end
          end
          ST_START: begin
            state_q <= ST_WAIT;
`ifdef BNN_CTRL_TIMEOUT_EN
            wd_q    <= '0;
`endif
          end
          ST_WAIT: begin
            // a level left high from before WAIT is not a completion
            if (rdy_rise) begin
              result_class_q <= core_result;
              result_valid_q <= 1'b1;
              state_q        <= ST_DONE;
            end
`ifdef BNN_CTRL_TIMEOUT_EN
            else if (wd_expired) begin
              result_class_q <= ERR_CLASS;
              result_valid_q <= 1'b1;
              error_q        <= 1'b1;
              state_q        <= ST_DONE;
            end else begin
              wd_q <= wd_q + 1'b1;
            end
`endif
          end
          ST_DONE: begin
            if (bus.result_ack) begin
              state_q        <= ST_IDLE;
              result_valid_q <= 1'b0;
              busy_q         <= 1'b0;
`ifdef BNN_CTRL_TIMEOUT_EN
              error_q        <= 1'b0;
`endif
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.rx_ready     = rx_ready;
  assign bus.result_valid = result_valid_q;
  assign bus.result_class = result_class_q;
  assign core_start       = core_start_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_bnn_controller.sv
// Directed + randomized bench for bnn_controller with a transaction-level reference model.
module tb_bnn_controller;

  localparam int NPIX = 784;
  localparam int NB   = NPIX / 8;
  localparam int TO   = 16;
`ifdef BNN_CTRL_TIMEOUT_EN
  localparam int LAT1 = 10;
`else
  localparam int LAT1 = 20;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       core_result_ready = 1'b0;
  logic [7:0] core_result = 8'h00;
  logic       core_start;
  logic       busy;
  logic       error;
  logic       core_img [0:NPIX-1];

  bnn_controller_if bus ();

  always #5 clk = ~clk;

  bnn_controller #(.IMG_PIXELS(NPIX), .TIMEOUT_CYCLES(TO)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .bus               (bus),
    .clear             (clear),
    .core_start        (core_start),
    .core_img          (core_img),
    .core_result_ready (core_result_ready),
    .core_result       (core_result),
    .busy              (busy),
    .error             (error)
  );

  int         n_cmp = 0;
  int         n_mis = 0;
  logic       exp_img [0:NPIX-1];
  logic [7:0] img_bytes [0:NB-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int img_diffs();
    int d = 0;
    for (int p = 0; p < NPIX; p++)
      if (core_img[p] !== exp_img[p]) d++;
    return d;
  endfunction

  function automatic int img_ones();
    int c = 0;
    for (int p = 0; p < NPIX; p++)
      if (core_img[p] !== 1'b0) c++;
    return c;
  endfunction

  task automatic model_store(input int k, input logic [7:0] b);
    for (int i = 0; i < 8; i++) exp_img[8*k+i] = b[7-i];
  endtask

  // Streams img_bytes with optional idle gaps; ends sampled in the START cycle.
  task automatic load_image(input int gap_pct, input bit hold, input logic [7:0] hold_byte);
    for (int k = 0; k < NB; k++) begin
      for (int g = 0; g < 3 && $urandom_range(99) < gap_pct; g++) begin
        bus.rx_valid = 1'b0;
        tick();
        chk("gap_no_start", core_start, 1'b0);
      end
      bus.rx_valid = 1'b1;
      bus.rx_data  = img_bytes[k];
      chk("rx_ready_load", bus.rx_ready, 1'b1);
      chk("no_early_start", core_start, 1'b0);
      tick();
      model_store(k, img_bytes[k]);
      chk("busy_load", busy, 1'b1);
    end
    bus.rx_valid = hold;
    bus.rx_data  = hold_byte;
    chk("core_start_pulse", core_start, 1'b1);
    chk("rx_ready_start", bus.rx_ready, 1'b0);
    chk("img_after_load", img_diffs(), 0);
  endtask

  task automatic respond(input int lat, input logic [7:0] cls);
    for (int t = 1; t <= lat; t++) begin
      tick();
      chk("start_single", core_start, 1'b0);
      chk("wait_no_valid", bus.result_valid, 1'b0);
      chk("wait_rx_ready", bus.rx_ready, 1'b0);
    end
    core_result_ready = 1'b1;
    core_result       = cls;
    tick();
    chk("done_valid", bus.result_valid, 1'b1);
    chk("done_class", bus.result_class, cls);
    chk("done_busy", busy, 1'b1);
  endtask

  task automatic ack(input int hold, input logic [7:0] cls);
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("done_hold_valid", bus.result_valid, 1'b1);
      chk("done_hold_class", bus.result_class, cls);
      chk("done_rx_ready", bus.rx_ready, 1'b0);
      chk("done_img_stable", img_diffs(), 0);
    end
    bus.result_ack = 1'b1;
    tick();
    bus.result_ack    = 1'b0;
    core_result_ready = 1'b0;
    chk("ack_valid_low", bus.result_valid, 1'b0);
    chk("ack_idle_busy", busy, 1'b0);
    chk("ack_rx_ready", bus.rx_ready, 1'b1);
  endtask

  initial begin
    logic [7:0] cls;
    bus.rx_valid   = 1'b0;
    bus.rx_data    = 8'h00;
    bus.result_ack = 1'b0;
    for (int p = 0; p < NPIX; p++) exp_img[p] = 1'b0;

    // reset
    tick();
    tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", bus.result_valid, 1'b0);
    chk("rst_start", core_start, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_img", img_ones(), 0);
    chk("rst_class", bus.result_class, 8'h00);
    rst_n = 1'b1;
    tick();
    chk("post_rst_rx_ready", bus.rx_ready, 1'b1);

    // 98 x 0xAA, core answers class 7
    for (int k = 0; k < NB; k++) img_bytes[k] = 8'hAA;
    load_image(0, 1'b0, 8'h00);
    chk("aa_img0", core_img[0], 1'b1);
    chk("aa_img1", core_img[1], 1'b0);
    respond(LAT1, 8'd7);
    ack(2, 8'd7);

    // rx_valid held through WAIT/DONE; byte taken only after ack
    for (int k = 0; k < NB; k++) img_bytes[k] = 8'($urandom_range(255));
    cls = 8'($urandom_range(254));
    load_image(20, 1'b1, 8'h5A);
    respond($urandom_range(1, 12), cls);
    ack(3, cls);
    chk("held_not_taken", img_diffs(), 0);
    tick();
    model_store(0, 8'h5A);
    chk("held_taken_after_ack", img_diffs(), 0);
    chk("held_load_busy", busy, 1'b1);
    bus.rx_valid = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_from_load", busy, 1'b0);

    // clear after 50 bytes, simultaneous byte must be dropped
    for (int k = 0; k < 50; k++) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'($urandom_range(255));
      tick();
      model_store(k, bus.rx_data);
    end
    bus.rx_data = ~exp_img[400] ? 8'hFF : 8'h00;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    bus.rx_valid = 1'b0;
    chk("clear_idle_busy", busy, 1'b0);
    chk("clear_rx_ready", bus.rx_ready, 1'b1);
    chk("clear_beats_accept", img_diffs(), 0);
    for (int k = 0; k < NB; k++) img_bytes[k] = 8'hFF;
    load_image(0, 1'b0, 8'h00);
    chk("ff_no_residue", NPIX - img_ones(), 0);
    respond(3, 8'd2);
    ack(0, 8'd2);

    // randomized images
    for (int n = 0; n < 3; n++) begin
      for (int k = 0; k < NB; k++) img_bytes[k] = 8'($urandom_range(255));
      cls = 8'($urandom_range(254));
      load_image(30, 1'b0, 8'h00);
      respond($urandom_range(1, 12), cls);
      ack($urandom_range(0, 4), cls);
    end

    // silent core
    for (int k = 0; k < NB; k++) img_bytes[k] = 8'($urandom_range(255));
    load_image(0, 1'b0, 8'h00);
`ifdef BNN_CTRL_TIMEOUT_EN
    for (int t = 1; t <= TO; t++) begin
      tick();
      chk("wd_not_yet", bus.result_valid, 1'b0);
    end
    tick();
    chk("wd_valid", bus.result_valid, 1'b1);
    chk("wd_class", bus.result_class, 8'hFF);
    chk("wd_error", error, 1'b1);
    for (int h = 0; h < 3; h++) begin
      tick();
      chk("wd_error_hold", error, 1'b1);
    end
`else
    for (int t = 0; t < 1000; t++) tick();
    chk("nowd_busy", busy, 1'b1);
    chk("nowd_valid", bus.result_valid, 1'b0);
    chk("nowd_error", error, 1'b0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("nowd_clear", busy, 1'b0);
    load_image(0, 1'b0, 8'h00);
    respond(4, 8'd9);
`endif
    // clear together with ack in DONE
    clear          = 1'b1;
    bus.result_ack = 1'b1;
    tick();
    clear             = 1'b0;
    bus.result_ack    = 1'b0;
    core_result_ready = 1'b0;
    chk("clr_ack_busy", busy, 1'b0);
    chk("clr_ack_error", error, 1'b0);
    chk("clr_ack_valid", bus.result_valid, 1'b0);
    chk("clr_ack_rx_ready", bus.rx_ready, 1'b1);

    // reset during WAIT, core ready left high across release
    for (int k = 0; k < NB; k++) img_bytes[k] = 8'($urandom_range(255));
    load_image(0, 1'b0, 8'h00);
    tick();
    tick();
    core_result_ready = 1'b1;
    core_result       = 8'h33;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_start", core_start, 1'b0);
    chk("arst_valid", bus.result_valid, 1'b0);
    chk("arst_error", error, 1'b0);
    chk("arst_img", img_ones(), 0);
    chk("arst_rx_ready", bus.rx_ready, 1'b1);
    for (int p = 0; p < NPIX; p++) exp_img[p] = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < NB; k++) img_bytes[k] = 8'($urandom_range(255));
    load_image(10, 1'b0, 8'h00);
    for (int t = 0; t < 10; t++) begin
      tick();
      chk("stale_ignored", bus.result_valid, 1'b0);
    end
    core_result_ready = 1'b0;
    tick();
    cls = 8'($urandom_range(254));
    core_result_ready = 1'b1;
    core_result       = cls;
    tick();
    chk("fresh_edge_valid", bus.result_valid, 1'b1);
    chk("fresh_edge_class", bus.result_class, cls);
    ack(1, cls);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/bnn_controller.md
BNN_CONTROLLER -- requirements
Module: bnn_controller

Interface
REQ-001 SHALL have parameter IMG_PIXELS, default 784, meaning pixels per image; it must be a multiple of 8.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the WAIT watchdog limit (used only with BNN_CTRL_TIMEOUT_EN).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port rx_data, input, 8 bits: packed pixel byte.
REQ-006 SHALL have ports rx_valid (input, 1) and rx_ready (output, 1): byte handshake; a byte transfers when both are 1.
REQ-007 SHALL have port clear, input, 1 bit: synchronous abort.
REQ-008 SHALL have port core_start, output, 1 bit: one-cycle inference start pulse to the BNN core.
REQ-009 SHALL have port core_img, output, unpacked 1-bit array [0:IMG_PIXELS-1]: image to the core.
REQ-010 SHALL have ports core_result_ready (input, 1) and core_result (input, 8): core completion and class.
REQ-011 SHALL have ports result_valid (output, 1), result_class (output, 8) and result_ack (input, 1): result handshake.
REQ-012 SHALL have ports busy (output, 1) and error (output, 1).

Function
REQ-013 SHALL implement states IDLE, LOAD, START, WAIT and DONE.
REQ-014 SHALL drive rx_ready=1 only in IDLE and LOAD.
REQ-015 In IDLE, an accepted byte SHALL be stored as byte 0 and the state SHALL move to LOAD.
REQ-016 Byte k SHALL map core_img[8k+i] = rx_data[7-i], MSB first, i=0..7.
REQ-017 The byte counter SHALL be $clog2(IMG_PIXELS/8+1) bits wide and SHALL be cleared on entry to IDLE.
REQ-018 Acceptance of byte IMG_PIXELS/8-1 in cycle N SHALL cause START in N+1, with core_start=1 for exactly that cycle, then WAIT.
REQ-019 In WAIT, a rising edge of core_result_ready (registered previous value 0, current 1) SHALL latch core_result into result_class; DONE follows next cycle.
REQ-020 A level-high core_result_ready with no rising edge in WAIT SHALL be ignored as stale.
REQ-021 In DONE, result_valid SHALL be 1; result_class SHALL be held until result_ack=1, then the state SHALL return to IDLE and result_valid=0 next cycle.
REQ-022 core_img SHALL be stable from START through DONE and modified only by accepted bytes.
REQ-023 busy SHALL be 1 whenever state != IDLE.
REQ-024 clear=1 SHALL force IDLE next cycle from any state, zeroing the byte counter, result_valid and error.
REQ-025 clear SHALL take priority over a simultaneous byte accept, result_ack or core_result_ready edge.

Reset
REQ-026 rst_n=0 SHALL asynchronously force IDLE and set core_img, counter, result_class, core_start, result_valid, error, busy and the edge register to 0.
REQ-027 After reset release, rx_ready SHALL be 1 (IDLE).

Configuration
REQ-028 With BNN_CTRL_TIMEOUT_EN defined, a counter SHALL run in WAIT; on reaching TIMEOUT_CYCLES with no edge, the block SHALL go to DONE with result_class=8'hFF and error=1.
REQ-029 With BNN_CTRL_TIMEOUT_EN defined, error SHALL hold until result_ack or clear.
REQ-030 Without BNN_CTRL_TIMEOUT_EN, there SHALL be no watchdog logic; WAIT is unbounded and error is tied to 0.

Structure
REQ-031 Package bnn_pkg SHALL hold IMG_PIXELS=784, BYTES_PER_IMG=98, state enum bnn_ctrl_state_t and ERR_CLASS=8'hFF.
REQ-032 Byte counting and pixel unpacking SHALL live in sub-module bnn_img_loader; the FSM and watchdog SHALL live in bnn_controller.

Verification
REQ-033 The bench SHALL cover: reset, then 98 bytes 0xAA, with a core model giving ready 20 cycles after start with class 7 -> core_img[0]=1, core_img[1]=0, single core_start the cycle after byte 97, result_valid with 7, ack returns to IDLE.
REQ-034 The bench SHALL cover: rx_valid held high through WAIT/DONE -> rx_ready=0 and no byte consumed until the cycle after ack.
REQ-035 The bench SHALL cover: clear after 50 bytes -> IDLE; next 98 bytes of 0xFF -> all core_img=1 with no residue.
REQ-036 The bench SHALL cover: macro on, TIMEOUT_CYCLES=16, core silent -> result_class=0xFF and error=1 after 16 WAIT cycles; macro off -> busy=1 after 1000 cycles.
REQ-037 The bench SHALL cover: rst_n low during WAIT -> outputs 0 immediately; core_result_ready already high after release -> not taken as a result.
REQ-038 The bench SHALL cover: clear and result_ack together in DONE with error=1 -> IDLE and error=0 next cycle.
